// File: rtl/period_avg.sv
// Captures the final count of each upstream counter period, averages 2^LOG2N periods
// and presents the floored mean on a single-entry valid/ready output with saturation and drop flags.
module period_avg #(
  parameter int LOG2N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] b,
  input  logic       reset,
  output logic [4:0] out_data,
  output logic       out_sat,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       drop_err
);

  localparam int ACC_W = 5 + LOG2N;
  localparam int K_W   = (LOG2N > 0) ? LOG2N : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'((1 << LOG2N) - 1);

  typedef enum logic {SYNC = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [4:0]       b_q_r;
  logic             reset_q_r;
  logic             sat_pend_r, sat_pend_s;
  logic [K_W-1:0]   k_r, k_s;
  logic [ACC_W-1:0] acc_r, acc_s, sum_s;
  logic             win_sat_r, win_sat_s;
  logic             edge_s;
  logic [4:0]       sample_s;
  logic             res_vld_s;
  logic [4:0]       res_data_s;
  logic             res_sat_s;

  // Period-end decode, sample selection, window accumulation and next state
  always_comb begin
    edge_s     = reset & ~reset_q_r;
    sample_s   = sat_pend_r ? 5'd31 : b_q_r;
    sum_s      = acc_r + ACC_W'(sample_s);
    state_s    = state_r;
    k_s        = k_r;
    acc_s      = acc_r;
    win_sat_s  = win_sat_r;
    res_vld_s  = 1'b0;
    res_data_s = 5'd0;
    res_sat_s  = 1'b0;
    sat_pend_s = sat_pend_r;

    // A 31->0 step without a comparator reset means the real period exceeded the counter range
    if (edge_s) begin
      sat_pend_s = 1'b0;
    end else if ((b_q_r == 5'd31) && (b == 5'd0) && !reset) begin
      sat_pend_s = 1'b1;
    end else begin
      sat_pend_s = sat_pend_r;
    end

    case (state_r)
      SYNC: begin
        if (edge_s) begin
          state_s = RUN;
        end else begin
          state_s = SYNC;
        end
      end
      RUN: begin
        if (edge_s) begin
          if (k_r == K_LAST) begin
            res_vld_s  = 1'b1;
            res_data_s = 5'(sum_s >> LOG2N);
            res_sat_s  = win_sat_r | sat_pend_r;
            acc_s      = {ACC_W{1'b0}};
            k_s        = {K_W{1'b0}};
            win_sat_s  = 1'b0;
          end else begin
            acc_s      = sum_s;
            k_s        = k_r + K_W'(1);
            win_sat_s  = win_sat_r | sat_pend_r;
          end
        end else begin
          acc_s     = acc_r;
          k_s       = k_r;
          win_sat_s = win_sat_r;
        end
      end
      default: begin
        state_s = SYNC;
      end
    endcase
  end

  // Input history and accumulation state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= SYNC;
      b_q_r      <= 5'd0;
      reset_q_r  <= 1'b1;
      sat_pend_r <= 1'b0;
      k_r        <= {K_W{1'b0}};
      acc_r      <= {ACC_W{1'b0}};
      win_sat_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      b_q_r      <= b;
      reset_q_r  <= reset;
      sat_pend_r <= sat_pend_s;
      k_r        <= k_s;
      acc_r      <= acc_s;
      win_sat_r  <= win_sat_s;
    end
  end

  // Single-entry output slot; a result arriving while the slot is stalled is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= 5'd0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
      drop_err  <= 1'b0;
    end else if (res_vld_s) begin
      if (!out_valid || out_ready) begin
        out_data  <= res_data_s;
        out_sat   <= res_sat_s;
        out_valid <= 1'b1;
      end else begin
        drop_err  <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: doc/period_avg.md
# period_avg

Downstream consumer of the comparator-reset period counter. Watches the 5-bit cycle count `b` and its `reset` pulse, and captures the final count of each completed period. Accumulates 2^LOG2N periods and presents the truncated average on a valid/ready output for the readout logic. Counter wrap-around without a comparator reset is detected and reported as saturation; results dropped by a stalled consumer are flagged.

## Interface
- LOG2N, 2, log2 of periods averaged per result; legal range 0..4 (0 = pass-through of each period)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- b  in  5  upstream period counter; +1 per clock, forced to 0 while `reset` is high, wraps 31->0 if no reset occurs
- reset  in  1  upstream counter-reset flag; high for one or more cycles per comparator event
- out_data  out  5  averaged period in clock cycles
- out_sat  out  1  qualifies out_data; 1 if any period in the window saturated
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- drop_err  out  1  sticky; a finished result was discarded because the output was still occupied

## Operation
- Internal registers: b_q (b delayed one clock), reset_q, sat_pend, sample count k (0..2^LOG2N-1), accumulator acc (5+LOG2N bits), state.
- Period end event E: reset==1 && reset_q==0 (rising edge only; a multi-cycle reset high yields one E).
- Sample on E = 31 if sat_pend, else b_q. b is already 0 when reset rises, so b_q holds the final count.
- Wrap: b_q==31 && b==0 && reset==0 sets sat_pend. sat_pend clears on E. b_q==31 with reset rising is a genuine 31, unsaturated.
- States:
  - SYNC: entered on rst. First E is discarded because the period phase is unknown. Clears sat_pend, goes to RUN.
  - RUN: on each E, acc += sample, OR sample saturation into a window flag, k++.
  - Window end: on E with k==2^LOG2N-1, result = (acc+sample)>>LOG2N (floor), sat = window flag. acc, k and the flag clear for the next window; state stays RUN.
- Output register, single entry:
  - When a result is produced and the slot is empty or being transferred this cycle: load out_data/out_sat and set out_valid.
  - When a result is produced and out_valid && !out_ready: drop the result, set drop_err, keep the held result. Accumulation continues regardless.
  - Transfer when out_valid && out_ready. out_valid clears unless a new result loads in the same cycle.
- out_data and out_sat are stable while out_valid && !out_ready.
- Reset values:
  - out_data=0, out_sat=0, out_valid=0, drop_err=0, acc=0, k=0, sat_pend=0, b_q=0, state=SYNC.
  - reset_q=1, so a reset already high at rst release is not an edge.
- rst mid-window discards the partial window and any held result. The next window needs 1 discarded E plus 2^LOG2N fresh E.

## Timing
- E is decoded in the cycle where reset is first seen high. acc/k update at that cycle's closing edge.
- Result latency: out_valid is high in the cycle after the window-completing E (1 clock).
- Wrap detection costs 0 extra cycles; sat_pend is set at the edge closing the cycle where b==0 is seen.
- Minimum supported period: 2 cycles between successive E. Every E is captured with no lost events.
- drop_err sets at the edge closing the dropping cycle and clears only on rst.
- Throughput: one result per 2^LOG2N periods. Back-to-back transfer with a same-cycle reload keeps out_valid continuously high.

## Test plan
The bench models the upstream counter: b increments each clock and is held at 0 while reset is high.
- LOG2N=2, out_ready=1, rst then periods of 10 repeated: first E discarded; after 4 more E, out_data=10, out_sat=0, one out_valid pulse per 4 periods.
- Periods 10,11,12,14: out_data=11 (47>>2), out_sat=0.
- One period of 40 cycles (wrap) among three 10s: that sample is 31, out_data=15 (61>>2), out_sat=1. The next window has out_sat=0.
- out_ready=0 across two windows: first result held unchanged, second dropped, drop_err=1. Raising out_ready transfers the first result; the third window loads normally.
- reset held high 3 cycles counts as one E. rst after 2 samples, then 10-cycle periods: no out_valid until 1 discarded + 4 new E.
- out_valid && out_ready in the same cycle a new result completes: out_valid stays high, out_data updates to the new value, drop_err stays 0.
